// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: per-channel input streams, arbitration controls and the
// registered output stream. The slave modport is the mux side, master is the driver side.
interface rr_mux_if #(
  parameter int unsigned N  = 9,
  parameter int unsigned CH = 4
);
  localparam int unsigned SW = $clog2(CH);

  logic [CH*N-1:0] in;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [N-1:0]    out;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;

  modport master (
    output in, in_valid, sel, mode, out_ready,
    input  in_ready, out, out_valid, out_ch
  );

  modport slave (
    input  in, in_valid, sel, mode, out_ready,
    output in_ready, out, out_valid, out_ch
  );
endinterface

// File: rtl/rr_mux.sv
// CH-way arbitrating mux (fixed select or round-robin) into a single registered output slot.
// Define RR_MUX_XFER_CNT_EN to add a saturating 16-bit output-transfer counter port.
module rr_mux #(
  parameter int unsigned N  = 9,
  parameter int unsigned CH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RR_MUX_XFER_CNT_EN
  output logic [15:0] xfer_cnt,
`endif
  rr_mux_if.slave     bus
);
  localparam int unsigned SW = $clog2(CH);

  logic [N-1:0]  out_q;
  logic [SW-1:0] out_ch_q;
  logic          out_valid_q;
  logic [SW-1:0] ptr_q;

  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant_data;
  logic          load_en;
  logic          in_xfer;
  logic [CH-1:0] rdy;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      if (32'(bus.sel) < CH && bus.in_valid[bus.sel]) begin
        grant_vld = 1'b1;
        grant_idx = bus.sel;
      end
    end else begin
      // Search starts just after the last winner and ends at the last winner itself.
      for (int unsigned i = 1; i <= CH; i++) begin
        idx = (32'(ptr_q) + i) % CH;
        if (!grant_vld && bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx[SW-1:0];
        end
      end
    end
  end

  assign grant_data = bus.in[32'(grant_idx)*N +: N];
  assign load_en    = !out_valid_q || bus.out_ready;
  // rst_n gates the grant so in_ready is low for the whole time reset is held.
  assign in_xfer    = rst_n && load_en && grant_vld;

  always_comb begin
    rdy = '0;
    if (in_xfer) rdy[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(CH - 1);
    end else if (in_xfer) begin
      out_q       <= grant_data;
      out_ch_q    <= grant_idx;
      out_valid_q <= 1'b1;
      ptr_q       <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef RR_MUX_XFER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter N, default 9, data width in bits per channel.
REQ-002 Parameter CH, default 4, channel count, legal range 2..16; SW = $clog2(CH).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 In  input  CH*N  flattened channel data; channel k occupies bits [k*N+N-1 : k*N].
REQ-006 In_valid  input  CH  per-channel valid.
REQ-007 In_ready  output  CH  per-channel ready, at most one bit high per cycle.
REQ-008 Sel  input  SW  channel select used in fixed mode.
REQ-009 Mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 Out  output  N  registered output data.
REQ-011 Out_valid  output  1  Out holds a valid word.
REQ-012 Out_ready  input  1  downstream accepts Out.
REQ-013 Out_ch  output  SW  channel index of the word in Out.

Function
REQ-014 Transfer on channel k occurs when In_valid[k] and In_ready[k] are both high at a rising clk edge; output transfer occurs when Out_valid and Out_ready are both high.
REQ-015 load_en = !Out_valid || Out_ready; In_ready is all-zero whenever load_en is low.
REQ-016 Fixed mode: grant = Sel, issued only when In_valid[Sel] is high; other channels are never granted.
REQ-017 Round-robin mode: grant = first k with In_valid[k] high, searching ptr+1, ptr+2, ... mod CH, ending at ptr itself.
REQ-018 ptr (SW bits) updates to the granted index only on an input transfer, in either mode; otherwise it holds.
REQ-019 On input transfer: Out <= granted data, Out_ch <= granted index, Out_valid <= 1, with one-cycle latency.
REQ-020 Output transfer with no simultaneous input transfer clears Out_valid; a simultaneous input transfer keeps Out_valid high and replaces Out with the new word (full throughput, one word per cycle).
REQ-021 Out and Out_ch are held stable while Out_valid is high and Out_ready is low.
REQ-022 No In_valid bit high (or In_valid[Sel] low in fixed mode) produces no grant, and ptr holds.
REQ-023 Mode and Sel are sampled combinationally each cycle; a change takes effect at the next arbitration and never alters a word already in Out.
REQ-024 Sel >= CH in fixed mode produces no grant.

Reset
REQ-025 Asserting rst_n low immediately forces Out_valid = 0, Out = 0, Out_ch = 0, ptr = CH-1 (so channel 0 has first priority), and drives In_ready to all-zero.
REQ-026 A word pending in Out at reset is discarded; the first grant after deassertion follows REQ-016/017 from the reset state.

Configuration
REQ-027 With macro RR_MUX_XFER_CNT_EN defined, the block adds output Xfer_cnt [15:0], which increments on every output transfer, saturates at 16'hFFFF and resets to 0.
REQ-028 Without RR_MUX_XFER_CNT_EN, the port and its counter are absent; all other behaviour is identical.

Verification
REQ-029 N=9, CH=4, Mode=0, Sel=2, In_valid=4'b1111, ch2 data=9'h155, Out_ready=1 -> In_ready=4'b0100; next cycle Out=9'h155, Out_ch=2, Out_valid=1.
REQ-030 Mode=1, In_valid=4'b1111 held, Out_ready=1 from reset -> Out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 Mode=1, In_valid=4'b1010, Out_ready=0 after first load -> Out_ch=1 is held, Out is stable, In_ready=0; on Out_ready=1 the next Out_ch=3.
REQ-032 Mode=0, Sel=3, In_valid=4'b0111 -> no grant, Out_valid stays 0, ptr unchanged.
REQ-033 rst_n pulsed low mid-stream with Out_valid=1 -> Out_valid=0 asynchronously; after release with In_valid=4'b1111 and Mode=1 -> first Out_ch=0.
REQ-034 With RR_MUX_XFER_CNT_EN, 5 output transfers -> Xfer_cnt=5; a counter preloaded to 16'hFFFF stays at 16'hFFFF after a further transfer.
